// File: rtl/ippcrc_crc32_stream_if.sv
// Purpose : framed data-in / CRC-result bundle for ippcrc_crc32_stream.
// Latency : n/a (signal bundle only).
// Backpr. : none; the engine accepts every valid word.
// Ports   : master drives mode/di_*, slave (the engine) drives crc_*/proto_err.
interface ippcrc_crc32_stream_if #(
  parameter int DW  = 64,
  parameter int NBW = (DW / 8 > 1) ? $clog2(DW / 8) : 1
);
  logic           mode;
  logic           di_vld;
  logic           di_sop;
  logic           di_eop;
  logic [NBW-1:0] di_nbyte;
  logic [DW-1:0]  di;
  logic           crc_vld;
  logic [31:0]    crc_out;
  logic           crc_err;
  logic           proto_err;

  modport master (
    output mode, di_vld, di_sop, di_eop, di_nbyte, di,
    input  crc_vld, crc_out, crc_err, proto_err
  );

  modport slave (
    input  mode, di_vld, di_sop, di_eop, di_nbyte, di,
    output crc_vld, crc_out, crc_err, proto_err
  );
endinterface

// File: rtl/ippcrc_crc32_stream.sv
// Purpose : streaming CRC-32 (poly 04C11DB7, MSB-first) over framed DW-bit words, generate or check mode.
// Latency : result (crc_vld/crc_out/crc_err) and proto_err registered, one cycle after the eop/offending word.
// Backpr. : none; one word per cycle is always accepted, di_vld=0 simply holds state.
// Ports   : clk, rst_n (async active-low), io (slave modport: mode, di_vld/sop/eop/nbyte, di in;
//           crc_vld, crc_out, crc_err, proto_err out).
module ippcrc_crc32_stream #(
  parameter int          DW      = 64,
  parameter logic [31:0] INIT    = 32'hFFFF_FFFF,
  parameter logic [31:0] XOROUT  = 32'hFFFF_FFFF,
  parameter logic [31:0] RESIDUE = 32'hC704_DD7B
) (
  input logic                   clk,
  input logic                   rst_n,
  ippcrc_crc32_stream_if.slave  io
);

  localparam int          NB   = DW / 8;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d, base, upd;
  logic        mode_q, mode_d;
  logic [31:0] nxt [1:NB];
  int          cnt;
  logic        start, accept, done, proto_d, err_d;
  logic        crc_vld_q, crc_err_q, proto_q;
  logic [31:0] crc_out_q;

  // k bytes of d, lane 0 first; within a lane bit 0 is the first serial bit
  // (lanes arrive bit-reversed). Called with a constant k per instance, so each
  // call flattens into its own XOR network.
  function automatic logic [31:0] crc_bytes(input logic [31:0] c,
                                            input logic [DW-1:0] d,
                                            input int k);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < NB; i++) begin
      if (i < k) begin
        for (int j = 0; j < 8; j++) begin
          fb = r[31] ^ d[8*i+j];
          r  = {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
      end
    end
    return r;
  endfunction

  // A sop word always starts from INIT, so restart/abort needs no extra cycle.
  assign base = start ? INIT : crc_q;

  for (genvar k = 1; k <= NB; k++) begin : g_nbyte
    assign nxt[k] = crc_bytes(base, io.di, k);
  end

  always_comb begin
    start  = io.di_vld & io.di_sop;
    accept = start | (io.di_vld & (state_q == BUSY));
    done   = accept & io.di_eop;

    // Byte count only matters on eop; 0 (and anything out of range) means full word.
    cnt = NB;
    if (io.di_eop && (io.di_nbyte != '0) && (int'(io.di_nbyte) < NB))
      cnt = int'(io.di_nbyte);

    upd = nxt[NB];
    for (int k = 1; k < NB; k++) begin
      if (cnt == k) upd = nxt[k];
    end

    state_d = state_q;
    if (start)     state_d = io.di_eop ? IDLE : BUSY;
    else if (done) state_d = IDLE;

    // sop while a frame is open, or eop with no frame open.
    proto_d = io.di_vld & ((io.di_sop & (state_q == BUSY)) |
                           (~io.di_sop & io.di_eop & (state_q == IDLE)));

    mode_d = start ? io.mode : mode_q;
    crc_d  = accept ? upd : crc_q;
    err_d  = mode_d & (upd != RESIDUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q     <= INIT;
      mode_q    <= 1'b0;
      crc_vld_q <= 1'b0;
      crc_out_q <= 32'h0;
      crc_err_q <= 1'b0;
      proto_q   <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      mode_q    <= mode_d;
      crc_vld_q <= done;
      proto_q   <= proto_d;
      if (done) begin
        crc_out_q <= upd ^ XOROUT;
        crc_err_q <= err_d;
      end
    end
  end

  assign io.crc_vld   = crc_vld_q;
  assign io.crc_out   = crc_out_q;
  assign io.crc_err   = crc_err_q;
  assign io.proto_err = proto_q;

endmodule

// File: tb/tb_ippcrc_crc32_stream.sv
// Purpose : randomized bench for ippcrc_crc32_stream at DW = 8, 64 and 256 against a byte-table CRC model.
// Latency : results expected one cycle after eop; sampled on the falling edge.
// Backpr. : none; frames are streamed back-to-back or with random idle gaps.
module tb_ippcrc_crc32_stream;

  localparam logic [31:0] POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] XOROUT  = 32'hFFFF_FFFF;
  localparam logic [31:0] RESIDUE = 32'hC704_DD7B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ippcrc_crc32_stream_if #(.DW(8),   .NBW(1)) i8 ();
  ippcrc_crc32_stream_if #(.DW(64),  .NBW(3)) i64 ();
  ippcrc_crc32_stream_if #(.DW(256), .NBW(5)) i256 ();

  ippcrc_crc32_stream #(.DW(8))   u_dut8   (.clk(clk), .rst_n(rst_n), .io(i8.slave));
  ippcrc_crc32_stream #(.DW(64))  u_dut64  (.clk(clk), .rst_n(rst_n), .io(i64.slave));
  ippcrc_crc32_stream #(.DW(256)) u_dut256 (.clk(clk), .rst_n(rst_n), .io(i256.slave));

  int checks = 0;
  int errors = 0;
  int pe_seen = 0;
  int pe_exp = 0;

  logic [31:0] tbl [256];
  logic [7:0]  fb [$];     // bytes of the frame being sent, in wire order
  logic [34:0] expq [$];   // {instance, crc_err, crc_out}

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // Reference: classic byte-at-a-time table CRC, MSB-first, no reflection.
  function automatic logic [31:0] ref_reg();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (fb[i]) c = (c << 8) ^ tbl[c[31:24] ^ fb[i]];
    return c;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive(input int sel, input logic v, input logic s, input logic e,
                       input logic md, input logic [4:0] nb, input logic [255:0] w);
    case (sel)
      0: begin i8.di_vld = v;   i8.di_sop = s;   i8.di_eop = e;   i8.mode = md;
               i8.di_nbyte = nb[0:0];   i8.di = w[7:0]; end
      1: begin i64.di_vld = v;  i64.di_sop = s;  i64.di_eop = e;  i64.mode = md;
               i64.di_nbyte = nb[2:0];  i64.di = w[63:0]; end
      default: begin i256.di_vld = v; i256.di_sop = s; i256.di_eop = e; i256.mode = md;
               i256.di_nbyte = nb;      i256.di = w; end
    endcase
    @(posedge clk);
    #1;
    i8.di_vld = 1'b0;
    i64.di_vld = 1'b0;
    i256.di_vld = 1'b0;
  endtask

  task automatic idle_all();
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin i8.di_vld = 0;   i8.di_sop = 0;   i8.di_eop = 0;   i8.mode = 0;   i8.di_nbyte = '0;   i8.di = '0; end
        1: begin i64.di_vld = 0;  i64.di_sop = 0;  i64.di_eop = 0;  i64.mode = 0;  i64.di_nbyte = '0;  i64.di = '0; end
        default: begin i256.di_vld = 0; i256.di_sop = 0; i256.di_eop = 0; i256.mode = 0; i256.di_nbyte = '0; i256.di = '0; end
      endcase
    end
  endtask

  // Streams fb into one instance. maxw >= 0 truncates after that many words (no eop).
  task automatic send_frame(input int sel, input logic md, input int gap_pct, input int maxw,
                            input logic fexp_en, input logic [32:0] fexp);
    int nbw, pos, words, rem;
    logic e;
    logic [255:0] w;
    logic [31:0] r;
    nbw = (sel == 0) ? 1 : (sel == 1) ? 8 : 32;
    pos = 0;
    words = 0;
    while (pos < fb.size()) begin
      if (maxw >= 0 && words == maxw) return;
      if (pos > 0 && $urandom_range(99) < gap_pct) begin
        drive(sel, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), rand256());
        continue;
      end
      w = rand256();
      rem = fb.size() - pos;
      e = (rem <= nbw);
      for (int l = 0; l < nbw; l++) if (l < rem) w[8*l +: 8] = rev8(fb[pos+l]);
      if (e) begin
        r = ref_reg();
        expq.push_back(fexp_en ? {2'(sel), fexp}
                               : {2'(sel), md & (r != RESIDUE), r ^ XOROUT});
      end
      drive(sel, 1'b1, pos == 0, e, md,
            e ? ((rem < nbw) ? 5'(rem) : 5'd0) : 5'($urandom), w);
      pos += nbw;
      words++;
    end
  endtask

  task automatic rand_frame(input int sel, input logic md, input int len, input int gap);
    logic [31:0] o;
    fb.delete();
    for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
    if (md && $urandom_range(1) == 1) begin
      o = ref_reg() ^ XOROUT;
      for (int i = 3; i >= 0; i--) fb.push_back(o[8*i +: 8]);
    end
    send_frame(sel, md, gap, -1, 1'b0, 33'd0);
  endtask

  task automatic kat(input int sel);
    int bi;
    fb = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(sel, 1'b0, 0, -1, 1'b1, {1'b0, 32'hFC89_1918});
    fb.push_back(8'hFC); fb.push_back(8'h89); fb.push_back(8'h19); fb.push_back(8'h18);
    send_frame(sel, 1'b1, 0, -1, 1'b1, {1'b0, 32'h38FB_2284});
    bi = $urandom_range(12);
    fb[bi] = fb[bi] ^ (8'h01 << $urandom_range(7));
    send_frame(sel, 1'b1, 0, -1, 1'b0, 33'd0);
  endtask

  task automatic mon(input int sel, input logic v, input logic [31:0] o,
                     input logic er, input logic pe);
    logic [34:0] x;
    if (pe) pe_seen++;
    if (v) begin
      if (expq.size() == 0) begin
        chk("unexpected_vld", 64'(v), 64'd0);
      end else begin
        x = expq.pop_front();
        chk("result_inst", 64'(sel), 64'(x[34:33]));
        chk("crc_out", 64'(o), 64'(x[31:0]));
        chk("crc_err", 64'(er), 64'(x[32]));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, i8.crc_vld,   i8.crc_out,   i8.crc_err,   i8.proto_err);
      mon(1, i64.crc_vld,  i64.crc_out,  i64.crc_err,  i64.proto_err);
      mon(2, i256.crc_vld, i256.crc_out, i256.crc_err, i256.proto_err);
    end
  end

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 256; i++) begin
      r = 32'(i) << 24;
      for (int j = 0; j < 8; j++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
      tbl[i] = r;
    end
    idle_all();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_i8",   64'({i8.crc_vld,   i8.crc_err,   i8.proto_err,   i8.crc_out}),   64'd0);
    chk("rst_i64",  64'({i64.crc_vld,  i64.crc_err,  i64.proto_err,  i64.crc_out}),  64'd0);
    chk("rst_i256", 64'({i256.crc_vld, i256.crc_err, i256.proto_err, i256.crc_out}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known answers and single-bit corruption at every width
    for (int s = 0; s < 3; s++) kat(s);

    // Minimum frame: one zero byte
    fb = '{8'h00};
    send_frame(1, 1'b0, 0, -1, 1'b0, 33'd0);
    send_frame(0, 1'b0, 0, -1, 1'b0, 33'd0);

    // Partial last word sweep (all eop byte counts), random garbage in unused lanes
    for (int len = 1; len <= 24; len++) rand_frame(1, 1'($urandom), len, 0);
    for (int len = 1; len <= 40; len += 3) rand_frame(2, 1'($urandom), len, 0);

    // Single-word frames every cycle, alternating mode
    for (int i = 0; i < 40; i++) rand_frame(1, 1'(i), $urandom_range(1, 8), 0);
    for (int i = 0; i < 10; i++) rand_frame(0, 1'(i), 1, 0);

    // Idle gaps inside frames
    for (int s = 0; s < 3; s++) rand_frame(s, 1'($urandom), 50, 40);

    // sop on an open frame aborts it and restarts
    for (int s = 0; s < 3; s++) begin
      fb.delete();
      for (int i = 0; i < 40; i++) fb.push_back(8'($urandom));
      send_frame(s, 1'($urandom), 0, 1, 1'b0, 33'd0);
      pe_exp++;
      rand_frame(s, 1'($urandom), $urandom_range(1, 45), 0);
    end

    // eop with no frame open is flagged; a bare mid word is silently dropped
    drive(1, 1'b1, 1'b0, 1'b1, 1'b0, 5'($urandom), rand256());
    pe_exp++;
    drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 5'($urandom), rand256());
    drive(0, 1'b1, 1'b0, 1'b1, 1'b1, 5'($urandom), rand256());
    pe_exp++;
    repeat (2) @(posedge clk);
    #1;
    chk("proto_cnt_mid", 64'(pe_seen), 64'(pe_exp));

    // Reset in the middle of a frame
    fb.delete();
    for (int i = 0; i < 30; i++) fb.push_back(8'($urandom));
    send_frame(1, 1'b1, 0, 2, 1'b0, 33'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_i64", 64'({i64.crc_vld, i64.crc_err, i64.proto_err, i64.crc_out}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rand_frame(1, 1'b0, 13, 0);
    rand_frame(1, 1'b1, 13, 0);

    // Random mix
    for (int i = 0; i < 60; i++)
      rand_frame($urandom_range(2), 1'($urandom), $urandom_range(1, 70), 20);

    repeat (4) @(posedge clk);
    #1;
    chk("results_drained", 64'(expq.size()), 64'd0);
    chk("proto_cnt_end", 64'(pe_seen), 64'(pe_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ippcrc_crc32_stream.md
# ippcrc_crc32_stream

Streaming, parametrised CRC-32 engine (polynomial 0x04C11DB7, MSB-first shift) for framed packet data on a DW-bit datapath. It accumulates the CRC across multi-word frames, handles a partial last word, and operates in generate mode (emits the FCS) or check mode (flags a bad FCS via the residue). It replaces fixed-width combinational CRC cells in the ippcrc package, sitting on Ethernet/GFP-style MAC/framer datapaths.

## Interface
- DW, 64: data width in bits, multiple of 8, 8..256.
- NBW, clog2(DW/8) (min 1): width of byte-count field.
- INIT, 32'hFFFFFFFF: CRC register value loaded at start of frame.
- XOROUT, 32'hFFFFFFFF: value XORed into the register to form crc_out.
- RESIDUE, 32'hC704DD7B: good-frame register value in check mode (before XOROUT).
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = generate, 1 = check; sampled on the sop word, held for the frame.
- di_vld  in  1  data word valid; no backpressure, engine always accepts.
- di_sop  in  1  first word of frame (qualified by di_vld).
- di_eop  in  1  last word of frame (qualified by di_vld).
- di_nbyte  in  NBW  valid bytes on eop word, counted from lane 0; 0 = all DW/8 bytes.
- di  in  DW  data; byte k in di[8k+7:8k], bit-reversed: di[8k] = byte bit 7. di[0] is the first bit into the CRC.
- crc_vld  out  1  one-cycle pulse: frame result valid.
- crc_out  out  32  register ^ XOROUT; crc_out[31] is the first FCS bit transmitted.
- crc_err  out  1  check mode: register != RESIDUE; always 0 in generate mode.
- proto_err  out  1  one-cycle pulse on a framing violation.

## Operation
- States: IDLE, BUSY. Reset state IDLE, CRC register = INIT.
- IDLE: a di_vld & di_sop word loads INIT, latches mode, and updates with the word. If di_eop is also set, the result is produced and the FSM stays in IDLE; otherwise it goes to BUSY.
- IDLE: a di_vld word without di_sop is dropped. If it carries di_eop, proto_err pulses.
- BUSY: a di_vld word without sop updates the register. With di_eop, the result is produced and the FSM goes to IDLE.
- BUSY: a di_vld & di_sop word aborts the open frame (no crc_vld) and pulses proto_err. It then restarts exactly as if in IDLE.
- di_vld = 0: the register and state hold. Idle gaps inside a frame are allowed.
- Partial word: on eop, only bytes 0..nbyte-1 enter the CRC, processed in lane order. Bytes at and above nbyte are ignored whatever their value.
- Non-eop words always use all DW/8 bytes; di_nbyte is ignored on them.
- Update logic: one combinational CRC-over-k-bytes function per k = 1..DW/8, muxed by the byte count. Each is a 32-bit XOR network equal to k×8 serial MSB-first LFSR steps.
- Check mode: the frame includes its 4-byte FCS. crc_err = (final register != RESIDUE). crc_out is still driven.
- Generate mode: the frame excludes the FCS. crc_out is the FCS to append; crc_err = 0.

## Timing
- Latency: crc_vld, crc_out, crc_err are registered and asserted the cycle after the eop word is accepted, for exactly one cycle.
- crc_out / crc_err hold their last values between pulses. Reset values: crc_out = 0, crc_err = 0, crc_vld = 0, proto_err = 0.
- proto_err is registered: it pulses the cycle after the offending word.
- Throughput: one word per cycle. Back-to-back frames are allowed, including eop in cycle N, sop in N+1, and single-word sop&eop frames every cycle.
- rst_n assertion mid-frame: immediate return to IDLE with the register = INIT. No crc_vld is produced for the truncated frame.
- Minimum frame: one byte (sop & eop, nbyte = 1).

## Test plan
- DW=64, generate: "123456789" as word 1 (8 bytes) + word 2 (nbyte=1, upper lanes random) -> crc_out = 32'hFC891918, crc_vld the cycle after word 2.
- Check mode: the same 9 bytes + FCS bytes FC 89 19 18 (13 bytes, eop nbyte=5) -> crc_err = 0. Flip any one data bit -> crc_err = 1.
- Single-byte frame 0x00, generate -> result equals a bit-accurate serial reference model. Sweep nbyte 0..7 on the eop word against the model; garbage in unused lanes must not matter.
- Back-to-back 1-word frames every cycle, alternating mode -> one crc_vld per frame with correct per-frame results; gaps (di_vld=0) inside a frame -> unchanged result.
- sop mid-frame -> proto_err pulse, no crc_vld for the first frame, and the second frame's CRC is correct. eop while IDLE -> proto_err, no crc_vld.
- Assert rst_n low mid-frame -> all outputs 0 next edge; the following frame's CRC is correct.
- Repeat the first two scenarios with DW=8 and DW=256.
